// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: req/ack word fetch into a small PC-tagged FIFO feeding decode.
// Optional JOPH_IF_DISCARD_COUNT_EN adds IF_discard_count (saturating dropped-response counter).
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 24,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}},
    parameter int                    DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  IF_mem_req,
    output logic [ADDR_WIDTH-1:0] IF_mem_addr,
    input  logic                  IF_mem_ack,
    input  logic [31:0]           IF_mem_rdata,
    input  logic                  IF_redirect,
    input  logic [ADDR_WIDTH-1:0] IF_redirect_addr,
    input  logic                  IF_halt,
    output logic                  IF_valid,
    output logic [31:0]           IF_instruction,
    output logic [ADDR_WIDTH-1:0] IF_pc,
    input  logic                  IF_ready
`ifdef JOPH_IF_DISCARD_COUNT_EN
    ,output logic [15:0]          IF_discard_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] fetch_pc_r;
    logic                  mem_req_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;

    logic [31:0]           instr_mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_r    [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [CNT_W-1:0]      count_r;

    logic                  ack_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  drop_s;
    logic [CNT_W-1:0]      count_next_s;
    logic                  room_s;
    logic [ADDR_WIDTH-1:0] pc_inc_s;
    logic [ADDR_WIDTH-1:0] next_pc_s;

    assign ack_s    = IF_mem_ack && mem_req_r;
    assign push_s   = ack_s && (state_r == ST_FETCH) && !IF_redirect;
    assign drop_s   = ack_s && ((state_r == ST_DISCARD) || IF_redirect);
    assign pop_s    = (count_r != {CNT_W{1'b0}}) && IF_ready;
    assign pc_inc_s = fetch_pc_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign room_s   = count_next_s < CNT_W'(DEPTH);

    // Occupancy after this cycle; a redirect flushes and overrides any pop.
    always_comb begin
        count_next_s = count_r;
        if (IF_redirect) begin
            count_next_s = {CNT_W{1'b0}};
        end else begin
            count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // PC that the next new request should use.
    always_comb begin
        next_pc_s = fetch_pc_r;
        if (IF_redirect) begin
            next_pc_s = IF_redirect_addr;
        end else if (push_s) begin
            next_pc_s = pc_inc_s;
        end else begin
            next_pc_s = fetch_pc_r;
        end
    end

    // Fetch control FSM with registered request/address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            mem_req_r  <= 1'b0;
            mem_addr_r <= RESET_PC;
        end else begin
            fetch_pc_r <= next_pc_s;
            case (state_r)
                ST_IDLE: begin
                    if (room_s && !IF_halt) begin
                        state_r    <= ST_FETCH;
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= next_pc_s;
                    end else begin
                        mem_req_r  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    // Pushed or dropped, the next address is next_pc_s (pc+1 or target).
                    if (ack_s) begin
                        if (room_s && !IF_halt) begin
                            mem_addr_r <= next_pc_s;
                        end else begin
                            state_r   <= ST_IDLE;
                            mem_req_r <= 1'b0;
                        end
                    end else if (IF_redirect) begin
                        state_r <= ST_DISCARD;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if (ack_s) begin
                        if (room_s && !IF_halt) begin
                            state_r    <= ST_FETCH;
                            mem_addr_r <= next_pc_s;
                        end else begin
                            state_r   <= ST_IDLE;
                            mem_req_r <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_DISCARD;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Instruction FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i] <= 32'h0000_0000;
                pc_mem_r[i]    <= {ADDR_WIDTH{1'b0}};
            end
        end else begin
            count_r <= count_next_s;
            if (IF_redirect) begin
                rd_ptr_r <= {PTR_W{1'b0}};
                wr_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (push_s) begin
                    instr_mem_r[wr_ptr_r] <= IF_mem_rdata;
                    pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
                    wr_ptr_r              <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

`ifdef JOPH_IF_DISCARD_COUNT_EN
    logic [15:0] discard_count_r;

    // Saturating count of memory responses thrown away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            discard_count_r <= 16'h0000;
        end else if (drop_s && (discard_count_r != 16'hFFFF)) begin
            discard_count_r <= discard_count_r + 16'h0001;
        end else begin
            discard_count_r <= discard_count_r;
        end
    end

    assign IF_discard_count = discard_count_r;
`else
    logic unused_drop_s;
    assign unused_drop_s = drop_s;
`endif

    assign IF_mem_req     = mem_req_r;
    assign IF_mem_addr    = mem_addr_r;
    assign IF_valid       = (count_r != {CNT_W{1'b0}});
    assign IF_instruction = IF_valid ? instr_mem_r[rd_ptr_r] : 32'h0000_0000;
    assign IF_pc          = IF_valid ? pc_mem_r[rd_ptr_r] : {ADDR_WIDTH{1'b0}};

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Table-driven bench for instruction_fetch_unit: per-cycle vectors plus a streaming sequence.
// Memory model answers with 0x40000000 | address whenever the bench raises ack.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [23:0] redirect_addr;
    logic        halt;
    logic        valid;
    logic [31:0] instruction;
    logic [23:0] pc;
    logic        ready;
    logic [15:0] dc_obs;

    int vectors;
    int miscompares;

`ifdef JOPH_IF_DISCARD_COUNT_EN
    logic [15:0] discard_count;
    assign dc_obs = discard_count;
`else
    assign dc_obs = 16'h0000;
`endif

    instruction_fetch_unit #(.ADDR_WIDTH(24), .RESET_PC(24'h000000), .DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .IF_mem_req       (mem_req),
        .IF_mem_addr      (mem_addr),
        .IF_mem_ack       (mem_ack),
        .IF_mem_rdata     (mem_rdata),
        .IF_redirect      (redirect),
        .IF_redirect_addr (redirect_addr),
        .IF_halt          (halt),
        .IF_valid         (valid),
        .IF_instruction   (instruction),
        .IF_pc            (pc),
        .IF_ready         (ready)
`ifdef JOPH_IF_DISCARD_COUNT_EN
        ,.IF_discard_count (discard_count)
`endif
    );

    assign mem_rdata = mem_ack ? (32'h4000_0000 | {8'h00, mem_addr}) : 32'h0000_0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n;
        logic        ack;
        logic        redir;
        logic [23:0] raddr;
        logic        halt;
        logic        ready;
        logic        e_req;
        logic [23:0] e_addr;
        logic        e_valid;
        logic [23:0] e_pc;
        logic [31:0] e_instr;
        logic [15:0] e_dc;
    } vec_t;

    localparam int NV = 34;
    vec_t vt [NV];

    task automatic setv(input int i, input logic r, input logic a, input logic rd,
                        input logic [23:0] ra, input logic h, input logic rdy,
                        input logic er, input logic [23:0] ea, input logic ev,
                        input logic [23:0] ep, input logic [31:0] ei, input logic [15:0] edc);
        vt[i].rst_n = r;   vt[i].ack = a;      vt[i].redir = rd;  vt[i].raddr = ra;
        vt[i].halt = h;    vt[i].ready = rdy;  vt[i].e_req = er;  vt[i].e_addr = ea;
        vt[i].e_valid = ev; vt[i].e_pc = ep;   vt[i].e_instr = ei; vt[i].e_dc = edc;
    endtask

    task automatic check_row(input int i);
        logic ok;
        ok = (mem_req === vt[i].e_req) && (mem_addr === vt[i].e_addr) &&
             (valid === vt[i].e_valid) && (pc === vt[i].e_pc) &&
             (instruction === vt[i].e_instr);
`ifdef JOPH_IF_DISCARD_COUNT_EN
        ok = ok && (dc_obs === vt[i].e_dc);
`endif
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL vec%0d: got req=%0b addr=%h valid=%0b pc=%h instr=%h dc=%h; want req=%0b addr=%h valid=%0b pc=%h instr=%h dc=%h",
                     i, mem_req, mem_addr, valid, pc, instruction, dc_obs,
                     vt[i].e_req, vt[i].e_addr, vt[i].e_valid, vt[i].e_pc, vt[i].e_instr, vt[i].e_dc);
        end
    endtask

    initial begin
        int          got;
        logic [23:0] exp_pc;
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0; mem_ack = 1'b0; redirect = 1'b0; redirect_addr = 24'h0;
        halt = 1'b0; ready = 1'b0;

        //   i  rst   ack   redir raddr       halt  ready | req  addr        valid pc          instr          dc
        // Streaming with ready=1
        setv( 0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 24'h000000, 32'h0000_0000, 16'd0);
        setv( 1, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'h000000, 1'b0, 24'h000000, 32'h0000_0000, 16'd0);
        setv( 2, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'h000001, 1'b1, 24'h000000, 32'h4000_0000, 16'd0);
        setv( 3, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'h000002, 1'b1, 24'h000001, 32'h4000_0001, 16'd0);
        // Reset mid-stream, then fill with ready=0
        setv( 4, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 24'h000000, 32'h0000_0000, 16'd0);
        setv( 5, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 24'h000000, 32'h0000_0000, 16'd0);
        setv( 6, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 24'h000000, 32'h0000_0000, 16'd0);
        setv( 7, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000001, 1'b1, 24'h000000, 32'h4000_0000, 16'd0);
        setv( 8, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000002, 1'b1, 24'h000000, 32'h4000_0000, 16'd0);
        setv( 9, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000003, 1'b1, 24'h000000, 32'h4000_0000, 16'd0);
        // Full: req drops; an ack with req=0 must be ignored
        setv(10, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000003, 1'b1, 24'h000000, 32'h4000_0000, 16'd0);
        setv(11, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h000003, 1'b1, 24'h000000, 32'h4000_0000, 16'd0);
        setv(12, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'h000004, 1'b1, 24'h000001, 32'h4000_0001, 16'd0);
        setv(13, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'h000004, 1'b1, 24'h000002, 32'h4000_0002, 16'd0);
        setv(14, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'h000004, 1'b1, 24'h000003, 32'h4000_0003, 16'd0);
        // Redirect while request pending, ack three cycles later is discarded
        setv(15, 1'b1, 1'b0, 1'b1, 24'h000100, 1'b0, 1'b0, 1'b1, 24'h000005, 1'b1, 24'h000004, 32'h4000_0004, 16'd0);
        setv(16, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000005, 1'b0, 24'h000000, 32'h0000_0000, 16'd0);
        setv(17, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000005, 1'b0, 24'h000000, 32'h0000_0000, 16'd0);
        setv(18, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000005, 1'b0, 24'h000000, 32'h0000_0000, 16'd0);
        setv(19, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000100, 1'b0, 24'h000000, 32'h0000_0000, 16'd1);
        setv(20, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000101, 1'b1, 24'h000100, 32'h4000_0100, 16'd1);
        // Redirect coincident with ack while two entries buffered (pop ignored)
        setv(21, 1'b1, 1'b1, 1'b1, 24'hFFFFFF, 1'b0, 1'b1, 1'b1, 24'h000102, 1'b1, 24'h000100, 32'h4000_0100, 16'd1);
        // PC wrap 0xFFFFFF -> 0x000000
        setv(22, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'hFFFFFF, 1'b0, 24'h000000, 32'h0000_0000, 16'd2);
        setv(23, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'h000000, 1'b1, 24'hFFFFFF, 32'h40FF_FFFF, 16'd2);
        // Halt: pending request completes, no new req, FIFO drains
        setv(24, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1, 24'h000001, 1'b1, 24'h000000, 32'h4000_0000, 16'd2);
        setv(25, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1, 24'h000001, 1'b1, 24'h000000, 32'h4000_0000, 16'd2);
        setv(26, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 24'h000001, 1'b1, 24'h000000, 32'h4000_0000, 16'd2);
        setv(27, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 24'h000001, 1'b1, 24'h000001, 32'h4000_0001, 16'd2);
        // Redirect while idle+halted, then release halt: fetch starts at target
        setv(28, 1'b1, 1'b0, 1'b1, 24'h000200, 1'b1, 1'b1, 1'b0, 24'h000001, 1'b0, 24'h000000, 32'h0000_0000, 16'd2);
        setv(29, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h000001, 1'b0, 24'h000000, 32'h0000_0000, 16'd2);
        setv(30, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'h000200, 1'b0, 24'h000000, 32'h0000_0000, 16'd2);
        // Reset asserted during pending request takes effect immediately
        setv(31, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 24'h000000, 32'h0000_0000, 16'd0);
        setv(32, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 24'h000000, 32'h0000_0000, 16'd0);
        setv(33, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 24'h000000, 32'h0000_0000, 16'd0);

        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n         = vt[i].rst_n;
            mem_ack       = vt[i].ack;
            redirect      = vt[i].redir;
            redirect_addr = vt[i].raddr;
            halt          = vt[i].halt;
            ready         = vt[i].ready;
            #1;
            check_row(i);
        end

        // Streaming with ack on alternate cycles: words 0..5 must emerge in order
        got    = 0;
        exp_pc = 24'h000000;
        for (int c = 0; c < 100 && got < 6; c++) begin
            @(negedge clk);
            mem_ack  = c[0];
            redirect = 1'b0;
            halt     = 1'b0;
            ready    = 1'b1;
            #1;
            if (valid) begin
                vectors++;
                if (pc !== exp_pc || instruction !== (32'h4000_0000 | {8'h00, exp_pc})) begin
                    miscompares++;
                    $display("FAIL stream%0d: got pc=%h instr=%h; want pc=%h instr=%h",
                             got, pc, instruction, exp_pc, 32'h4000_0000 | {8'h00, exp_pc});
                end
                exp_pc = exp_pc + 24'h000001;
                got++;
            end
        end
        if (got < 6) begin
            vectors++;
            miscompares++;
            $display("FAIL stream_timeout: got %0d words, want 6", got);
        end

        @(negedge clk);
        mem_ack = 1'b0;
        ready   = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
